// File: rtl/idm_banked_mem.sv
// rtl/idm_banked_mem.sv - banked instruction/data memory with byte lanes, wait states and self-clearing init
// Optional feature macro: IDM_WRITE_PROTECT_EN (drops writes to words below PROT_WORDS and flags err).
module idm_banked_mem #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 1,
   parameter int PROT_WORDS  = 11
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic                  ready,
   output logic                  rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  init_done,
   output logic                  err
);

   localparam int BYTES  = DATA_W / 8;
   localparam int LSB    = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IDX_W  = ADDR_W - LSB;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t              state;
   logic [MEM_AW-1:0]   init_cnt;
   logic [3:0]          wait_cnt;

   // Access latched at accept time and held until its ACCESS cycle
   logic [MEM_AW-1:0]   acc_idx;
   logic                acc_we;
   logic                acc_oor;
   logic                acc_prot;
   logic [DATA_W-1:0]   acc_wdata;
   logic [BYTES-1:0]    acc_be;

   // Word index decode of the incoming request
   logic [IDX_W-1:0]    req_idx;
   logic                req_oor;
   logic                req_prot;

   assign req_idx = addr[ADDR_W-1:LSB];
   assign req_oor = (32'(req_idx) >= DEPTH);

`ifdef IDM_WRITE_PROTECT_EN
   assign req_prot = (32'(req_idx) < PROT_WORDS);
`else
   // Without the protect feature the region bound has no effect
   logic unused_prot;
   assign unused_prot = (32'(req_idx) < PROT_WORDS);
   assign req_prot    = 1'b0;
`endif

   // Byte-offset bits of the address are ignored (word-aligned accesses)
   if (LSB > 0) begin : g_unused_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^addr[LSB-1:0];
   end

   // Control FSM: init sweep, accept, wait states, access and registered response
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= ST_INIT;
         init_cnt  <= '0;
         wait_cnt  <= '0;
         ready     <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         init_done <= 1'b0;
         err       <= 1'b0;
         acc_idx   <= '0;
         acc_we    <= 1'b0;
         acc_oor   <= 1'b0;
         acc_prot  <= 1'b0;
         acc_wdata <= '0;
         acc_be    <= '0;
      end else begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         case (state)
            ST_INIT: begin
               if (init_cnt == MEM_AW'(DEPTH - 1)) begin
                  state     <= ST_IDLE;
                  ready     <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (req) begin
                  acc_idx   <= req_idx[MEM_AW-1:0];
                  acc_we    <= we;
                  acc_oor   <= req_oor;
                  acc_prot  <= req_prot;
                  acc_wdata <= wdata;
                  acc_be    <= be;
                  ready     <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state <= ST_ACCESS;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= 4'(WAIT_CYCLES);
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt <= 4'd1) begin
                  state <= ST_ACCESS;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ACCESS: begin
               state <= ST_IDLE;
               ready <= 1'b1;
               if (!acc_we) begin
                  rvalid <= 1'b1;
                  rdata  <= acc_oor ? '0 : mem[acc_idx];
               end
               err <= acc_oor | (acc_we & acc_prot);
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // Storage: init clears one word per cycle; ACCESS commits enabled byte lanes
   always_ff @(posedge clock) begin
      if (reset) begin
         if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
         end else if (state == ST_ACCESS && acc_we && !acc_oor && !acc_prot) begin
            for (int i = 0; i < BYTES; i++) begin
               if (acc_be[i]) begin
                  mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
               end
            end
         end
      end
   end

endmodule
